// File: rtl/bcd_display_driver.sv
// Latches the converter's packed BCD result on its busy->idle edge and scans it
// onto a 4-digit common-anode 7-segment display with optional leading-zero blanking.
module bcd_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idle,
  input  logic [15:0] bcd,
  output logic [15:0] shown_value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned   PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic          idle_q;
  logic [PW-1:0] prescaler;
  logic [1:0]    digit_sel;
  logic [1:0]    next_sel;
  logic          tick;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_code;
  logic [3:0]    an_code;

  assign tick     = (prescaler == LAST);
  assign next_sel = digit_sel + 2'd1;

  // Slot contents are decoded for the digit about to be selected, from the
  // value latched before this edge, so a coincident capture shows one slot later.
  always_comb begin
    nibble = '0;
    blank  = 1'b0;
    unique case (next_sel)
      2'd0: nibble = shown_value[3:0];
      2'd1: nibble = shown_value[7:4];
      2'd2: nibble = shown_value[11:8];
      2'd3: nibble = shown_value[15:12];
    endcase
    unique case (next_sel)
      2'd1:    blank = (shown_value[15:4] == 12'd0);
      2'd2:    blank = (shown_value[15:8] == 8'd0);
      2'd3:    blank = (shown_value[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    if (BLANK_ZEROS == 1'b0) blank = 1'b0;

    unique case (nibble)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
    an_code = ~(4'b0001 << next_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown_value <= '0;
      idle_q      <= 1'b1;
      prescaler   <= '0;
      digit_sel   <= '0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
    end else begin
      idle_q <= idle;
      if (idle && !idle_q) shown_value <= bcd;
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        digit_sel <= next_sel;
        an        <= blank ? '1 : an_code;
        seg       <= blank ? '1 : seg_code;
      end
      dp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: blanking and non-blanking instances
// share stimulus; per-slot and per-capture expectations are queued and popped by monitors.
module tb_bcd_display_driver;

  localparam int unsigned RD = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        idle  = 1'b1;
  logic [15:0] bcd   = '0;

  logic [15:0] shown_b, shown_n;
  logic [3:0]  an_b, an_n;
  logic [6:0]  seg_b, seg_n;
  logic        dp_b, dp_n;

  int vectors     = 0;
  int miscompares = 0;
  int cnt         = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  an_nb;
    logic [6:0]  seg_nb;
    logic [15:0] shown;
  } slot_t;

  typedef struct {
    logic [15:0] val;
    int          at;
  } cap_t;

  slot_t slot_q[$];
  cap_t  cap_q[$];

  bcd_display_driver #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b1)) dut (
    .clk(clk), .reset(reset), .idle(idle), .bcd(bcd),
    .shown_value(shown_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  bcd_display_driver #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .idle(idle), .bcd(bcd),
    .shown_value(shown_n), .an(an_n), .seg(seg_n), .dp(dp_n)
  );

  always #5 clk = ~clk;

  // Edges since reset release; scan ticks land on every RD-th edge.
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 0;
    else       cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_slot(input logic [3:0] a, input logic [6:0] s,
                          input logic [3:0] a_nb, input logic [6:0] s_nb,
                          input logic [15:0] v);
    slot_t e;
    e.an = a; e.seg = s; e.an_nb = a_nb; e.seg_nb = s_nb; e.shown = v;
    slot_q.push_back(e);
  endtask

  task automatic exp_cap(input logic [15:0] v, input int at);
    cap_t c;
    c.val = v; c.at = at;
    cap_q.push_back(c);
  endtask

  task automatic to_cnt(input int n);
    int budget;
    budget = 300;
    while (cnt != n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (cnt != n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cnt: got cnt %0d, expected %0d within budget", cnt, n);
    end
  endtask

  // Slot monitor: one expectation per scan tick
  initial begin : tick_mon
    slot_t s;
    forever begin
      @(negedge clk);
      if (!reset && cnt != 0 && (cnt % RD) == 0) begin
        if (slot_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tick_unexpected@%0d: got an=%h seg=%h, expected no tick", cnt, an_b, seg_b);
        end else begin
          s = slot_q.pop_front();
          chk($sformatf("an@%0d", cnt),       32'(an_b),    32'(s.an));
          chk($sformatf("seg@%0d", cnt),      32'(seg_b),   32'(s.seg));
          chk($sformatf("an_nb@%0d", cnt),    32'(an_n),    32'(s.an_nb));
          chk($sformatf("seg_nb@%0d", cnt),   32'(seg_n),   32'(s.seg_nb));
          chk($sformatf("shown@%0d", cnt),    32'(shown_b), 32'(s.shown));
          chk($sformatf("dp@%0d", cnt),       32'(dp_b),    32'd1);
        end
      end
    end
  end

  // Capture monitor: any change of shown_value outside reset must match the next queued capture
  initial begin : cap_mon
    logic [15:0] last;
    cap_t c;
    last = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last = shown_b;
      end else if (shown_b !== last) begin
        if (cap_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cap_unexpected@%0d: got shown %h, expected no capture", cnt, shown_b);
        end else begin
          c = cap_q.pop_front();
          chk("cap_val",    32'(shown_b), 32'(c.val));
          chk("cap_val_nb", 32'(shown_n), 32'(c.val));
          chk("cap_edge",   32'(cnt),     32'(c.at));
        end
        last = shown_b;
      end
    end
  end

  // Reset monitor: outputs must go dark without waiting for a clock edge
  initial begin : rst_mon
    forever begin
      @(posedge reset);
      #1;
      chk("rst_an",    32'(an_b),    32'hF);
      chk("rst_seg",   32'(seg_b),   32'h7F);
      chk("rst_dp",    32'(dp_b),    32'd1);
      chk("rst_shown", 32'(shown_b), 32'h0);
      chk("rst_an_nb", 32'(an_n),    32'hF);
    end
  end

  initial begin : watchdog
    #50000;
    miscompares++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1234 captured on the tick edge: first slot still shows the old (zero) value
    exp_slot(4'hF, 7'h7F, 4'hD, 7'h40, 16'h1234);
    exp_slot(4'hB, 7'h24, 4'hB, 7'h24, 16'h1234);
    exp_slot(4'h7, 7'h79, 4'h7, 7'h79, 16'h1234);
    exp_slot(4'hE, 7'h19, 4'hE, 7'h19, 16'h1234);
    exp_slot(4'hD, 7'h30, 4'hD, 7'h30, 16'h1234);
    exp_slot(4'hF, 7'h7F, 4'hB, 7'h40, 16'h0007);
    exp_slot(4'hF, 7'h7F, 4'h7, 7'h40, 16'h0007);
    exp_slot(4'hE, 7'h78, 4'hE, 7'h78, 16'h0007);
    exp_slot(4'hF, 7'h7F, 4'hD, 7'h40, 16'h0007);
    exp_slot(4'hF, 7'h7F, 4'hB, 7'h40, 16'h00A5);
    exp_slot(4'hF, 7'h7F, 4'h7, 7'h40, 16'h00A5);
    exp_slot(4'hE, 7'h12, 4'hE, 7'h12, 16'h00A5);
    exp_slot(4'hD, 7'h3F, 4'hD, 7'h3F, 16'h00A5);
    exp_slot(4'hF, 7'h7F, 4'hB, 7'h40, 16'h0000);
    exp_slot(4'hF, 7'h7F, 4'h7, 7'h40, 16'h0000);
    exp_slot(4'hE, 7'h40, 4'hE, 7'h40, 16'h0000);
    exp_slot(4'hF, 7'h7F, 4'hD, 7'h40, 16'h0000);
    exp_slot(4'hB, 7'h40, 4'hB, 7'h40, 16'h1000);
    exp_slot(4'h7, 7'h79, 4'h7, 7'h79, 16'h1000);
    exp_slot(4'hE, 7'h40, 4'hE, 7'h40, 16'h1000);
    exp_slot(4'hD, 7'h40, 4'hD, 7'h40, 16'h1000);
    exp_cap(16'h1234, 4);
    exp_cap(16'h0007, 23);
    exp_cap(16'h00A5, 39);
    exp_cap(16'h0000, 55);
    exp_cap(16'h1000, 71);

    reset = 1'b0;
    to_cnt(0);  idle = 1'b0; bcd = 16'h1234;
    to_cnt(3);  idle = 1'b1;
    to_cnt(5);  bcd = 16'h5678;
    to_cnt(21); idle = 1'b0; bcd = 16'h0007;
    to_cnt(22); idle = 1'b1;
    to_cnt(37); idle = 1'b0; bcd = 16'h00A5;
    to_cnt(38); idle = 1'b1;
    to_cnt(53); idle = 1'b0; bcd = 16'h0000;
    to_cnt(54); idle = 1'b1;
    to_cnt(69); idle = 1'b0; bcd = 16'h1000;
    to_cnt(70); idle = 1'b1;

    // Reset mid-scan while a non-zero value is latched
    to_cnt(86);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    exp_slot(4'hD, 7'h78, 4'hD, 7'h78, 16'h9876);
    exp_slot(4'hB, 7'h00, 4'hB, 7'h00, 16'h9876);
    exp_slot(4'h7, 7'h10, 4'h7, 7'h10, 16'h9876);
    exp_slot(4'hE, 7'h02, 4'hE, 7'h02, 16'h9876);
    exp_cap(16'h9876, 2);

    reset = 1'b0;
    to_cnt(0);  idle = 1'b0; bcd = 16'h9876;
    to_cnt(1);  idle = 1'b1;
    to_cnt(18);

    chk("slot_q_drained", 32'(slot_q.size()), 32'd0);
    chk("cap_q_drained",  32'(cap_q.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
